// File: rtl/regfile_dumper.sv
// Debug read-out engine: walks register-file read addresses (all, or one selected register),
// captures each read word and streams it to the host over a valid/ready handshake.
module regfile_dumper #(
  parameter int unsigned REGFILE_ADDRESS_WIDTH = 3,
  parameter int unsigned DATA_WIDTH            = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             single,
  input  logic [REGFILE_ADDRESS_WIDTH-1:0] single_addr,
  output logic [REGFILE_ADDRESS_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0]            rf_rdata,
  output logic [DATA_WIDTH-1:0]            dump_data,
  output logic [REGFILE_ADDRESS_WIDTH-1:0] dump_addr,
  output logic                             dump_valid,
  input  logic                             dump_ready,
  output logic                             dump_last,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AW = REGFILE_ADDRESS_WIDTH;

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         end_q, end_d;
  logic [AW-1:0]         raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  last_q, last_d;

  logic [AW-1:0]         load_addr;
  logic [AW-1:0]         load_end;
  logic [AW-1:0]         cnt_inc;

  assign load_addr = single ? single_addr : '0;
  assign load_end  = single ? single_addr : '1;
  // Terminal detection uses end_q, so the increment never needs to wrap.
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    raddr_d = raddr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = load_addr;
          end_d   = load_end;
          raddr_d = load_addr;
          state_d = StRead;
        end
      end
      StRead: begin
        data_d  = rf_rdata;
        addr_d  = cnt_q;
        last_d  = (cnt_q == end_q);
        state_d = StSend;
      end
      StSend: begin
        if (dump_ready) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_inc;
            raddr_d = cnt_inc;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      end_q   <= '0;
      raddr_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      raddr_q <= raddr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign rf_raddr   = raddr_q;
  assign dump_data  = data_q;
  assign dump_addr  = addr_q;
  assign dump_last  = last_q;
  assign dump_valid = (state_q == StSend);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug read-out engine on the far side of the CPU register file from the writeback path. It sequences through register-file read addresses, one per word or just one selected register, and captures each read word. Each captured word is streamed to the host/debug interface over a valid/ready handshake. It connects to one combinational read port of the register file and never writes it.

## Interface
Parameters:
- REGFILE_ADDRESS_WIDTH, 3, register-file address width; the dump covers 2^REGFILE_ADDRESS_WIDTH registers
- DATA_WIDTH, 64, register word width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- single  in  1  qualifies start: 1 = read only single_addr, 0 = read all registers
- single_addr  in  REGFILE_ADDRESS_WIDTH  target register for single mode; sampled with start
- rf_raddr  out  REGFILE_ADDRESS_WIDTH  read address to the register-file read port
- rf_rdata  in  DATA_WIDTH  combinational read data from the register file
- dump_data  out  DATA_WIDTH  captured register word
- dump_addr  out  REGFILE_ADDRESS_WIDTH  register index of dump_data
- dump_valid  out  1  dump_data/dump_addr/dump_last valid
- dump_ready  in  1  consumer accepts the word when dump_valid && dump_ready
- dump_last  out  1  marks the final word of the current dump
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- FSM states:
  - IDLE: busy=0. On start, latch the mode, load cnt with 0 (full mode) or single_addr (single mode), latch end_addr as all-ones (full mode) or single_addr (single mode), and go to READ. Otherwise stay in IDLE.
  - READ: rf_raddr=cnt. At the rising edge, capture rf_rdata into dump_data and cnt into dump_addr. Set dump_last=(cnt==end_addr) and go to SEND.
  - SEND: dump_valid=1 and all outputs held stable. On dump_valid && dump_ready:
    - if dump_last, go to DONE;
    - otherwise increment cnt and go to READ.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- rf_raddr is registered; it equals cnt in READ and holds its last value elsewhere.
- Register 0 reads as 0 from the register file. The dumper passes it through unmodified.
- Snapshot semantics: dump_data is frozen once captured. Register writes during SEND do not alter the held word.
- Same-cycle write: the register file writes on the falling clock edge. A write to rf_raddr during the READ cycle is therefore visible at the capturing rising edge, and the new value is captured.
- In full mode cnt counts 0..2^AW-1 with no wrap. The terminal comparison uses end_addr, not cnt overflow.
- start while busy is ignored, whether it arrives in READ, SEND or DONE.
- dump_ready may be held high permanently or toggled arbitrarily. The dumper must not drop or repeat a word.

## Timing
- Reset values: rf_raddr=0, dump_data=0, dump_addr=0, dump_valid=0, dump_last=0, busy=0, done=0; FSM in IDLE, cnt=0.
- Reset asserted mid-dump returns to IDLE on the next edge with the reset values above. No done pulse is produced and the partial dump is discarded.
- start sampled at edge 0: READ during cycle 1 and dump_valid first high in cycle 2.
- Minimum of 2 cycles per word with dump_ready held high, one READ cycle plus one SEND cycle.
- Full dump, AW=3, ready always high: 16 cycles from start to the last handshake, then done in the following cycle. busy is high for 17 cycles.
- Single dump: dump_valid and dump_last are high together in cycle 2, and done follows the handshake by one cycle.
- busy falls in the cycle after done. A new start is accepted in that IDLE cycle, giving back-to-back dumps.

## Test plan
- Reset, preload regs 1..7 with 64'h11..77, full dump with ready=1 -> 8 words with addr 0..7 and data 0,11,..,77; dump_last only on addr 7; done 1 cycle after, 17 busy cycles total.
- Single dump with single_addr=5 and reg5=64'hDEADBEEF_CAFEF00D -> exactly one word {addr=5, data=DEADBEEF_CAFEF00D, last=1}; done follows.
- Full dump with dump_ready toggled pseudo-randomly, including 10-cycle stalls -> outputs stable while stalled; exactly 8 ordered words, none dropped or duplicated.
- Write reg3 on the falling edge of the READ cycle for addr 3 -> new value captured; write reg3 again during SEND -> dump_data unchanged.
- Reset pulsed while in SEND for addr 4 -> next cycle dump_valid=0, busy=0, no done; a new start then dumps from addr 0 normally.
- start pulses during an active dump and on the DONE cycle -> ignored; start on the IDLE cycle after done -> second dump starts immediately.
